// File: rtl/qq_decoder_if.sv
// QQ decoder bus: code word in, recovered frame fields out.
// Master drives code words; slave is the decoder.
interface qq_decoder_if;
  logic [3:0] code_in;
  logic [3:0] para1_out;
  logic [5:0] para2_out;
  logic [5:0] para3_out;
  logic [2:0] found;
  logic [3:0] err;
  logic       frame_valid;
  logic       busy;
  logic [7:0] stray_cnt;

  modport master (
    output code_in,
    input  para1_out, para2_out, para3_out,
    input  found, err, frame_valid, busy, stray_cnt
  );

  modport slave (
    input  code_in,
    output para1_out, para2_out, para3_out,
    output found, err, frame_valid, busy, stray_cnt
  );
endinterface

// File: rtl/qq_decoder.sv
// QQ marker decoder: frames on code_in[0], recovers
// para1/2/3 word indices and reports frame errors.
module qq_decoder (
  input  logic        clk_sys,
  input  logic        rst,
  qq_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic       full_q, full_d;
  logic [3:0] cap1_q, cap1_d;
  logic [5:0] cap2_q, cap2_d;
  logic [5:0] cap3_q, cap3_d;
  logic [2:0] fnd_q, fnd_d;
  logic [3:0] er_q, er_d;
  logic [3:0] p1_q, p1_d;
  logic [5:0] p2_q, p2_d;
  logic [5:0] p3_q, p3_d;
  logic [2:0] found_q, found_d;
  logic [3:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [7:0] stray_q, stray_d;
  logic [2:0] mk;
  logic       start;
  logic       adv;

  // Next state, frame capture and result publication.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    full_d  = full_q;
    cap1_d  = cap1_q;
    cap2_d  = cap2_q;
    cap3_d  = cap3_q;
    fnd_d   = fnd_q;
    er_d    = er_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    p3_d    = p3_q;
    found_d = found_q;
    err_d   = err_q;
    fv_d    = 1'b0;
    stray_d = stray_q;
    mk      = bus.code_in[3:1];
    start   = 1'b0;
    adv     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.code_in[0]) begin
          start = 1'b1;
        end else if (mk != 3'b000 &&
                     stray_q != 8'hff) begin
          stray_d = stray_q + 8'd1;
        end
      end
      RUN: begin
        if (bus.code_in[0]) begin
          adv = 1'b1;
        end else begin
          state_d = DONE;
          p1_d    = cap1_q;
          p2_d    = cap2_q;
          p3_d    = cap3_q;
          found_d = fnd_q;
          err_d   = er_q;
          fv_d    = 1'b1;
        end
      end
      DONE: begin
        if (bus.code_in[0]) begin
          start = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = RUN;
      idx_d   = 5'd0;
      full_d  = 1'b0;
      cap1_d  = 4'h0;
      cap2_d  = 6'h00;
      cap3_d  = 6'h00;
      fnd_d   = 3'b000;
      er_d    = 4'h0;
    end

    // full: index 31 already consumed; further words overflow.
    if (start || adv) begin
      if (full_d) begin
        er_d[3] = 1'b1;
      end else begin
        if ((mk & (mk - 3'd1)) != 3'b000) begin
          er_d[0] = 1'b1;
        end else if (mk != 3'b000) begin
          if ((fnd_d & mk) != 3'b000) begin
            er_d[1] = 1'b1;
          end else begin
            fnd_d = fnd_d | mk;
            if (mk[0]) begin
              cap1_d = idx_d[3:0];
              if (idx_d[4]) er_d[2] = 1'b1;
            end
            if (mk[1]) cap2_d = {1'b0, idx_d};
            if (mk[2]) cap3_d = {1'b0, idx_d};
          end
        end
        if (&idx_d) full_d = 1'b1;
        else idx_d = idx_d + 5'd1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      full_q  <= 1'b0;
      cap1_q  <= 4'h0;
      cap2_q  <= 6'h00;
      cap3_q  <= 6'h00;
      fnd_q   <= 3'b000;
      er_q    <= 4'h0;
      p1_q    <= 4'h0;
      p2_q    <= 6'h00;
      p3_q    <= 6'h00;
      found_q <= 3'b000;
      err_q   <= 4'h0;
      fv_q    <= 1'b0;
      stray_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
      cap1_q  <= cap1_d;
      cap2_q  <= cap2_d;
      cap3_q  <= cap3_d;
      fnd_q   <= fnd_d;
      er_q    <= er_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      found_q <= found_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      stray_q <= stray_d;
    end
  end

  assign bus.para1_out   = p1_q;
  assign bus.para2_out   = p2_q;
  assign bus.para3_out   = p3_q;
  assign bus.found       = found_q;
  assign bus.err         = err_q;
  assign bus.frame_valid = fv_q;
  assign bus.busy        = (state_q == RUN);
  assign bus.stray_cnt   = stray_q;

endmodule

// File: doc/qq_decoder.md
# qq_decoder

Receive-side decoder for the 4-bit QQ marker code produced by the sequence encoder. It sits on the acquisition board and consumes one code word per `clk_sys` cycle. It frames each sequence using the `state_start` bit and recovers the three marker positions (para1/para2/para3) as word indices within the frame. It also reports framing and marker errors, so the controller can cross-check the programmed QQ parameters against what actually went out on the line.

## Interface
- No parameters; all widths fixed.
- `clk_sys`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `code_in`  in  4  code word.
  - bit0 = `state_start`.
  - bit1 = para1 marker.
  - bit2 = para2 marker.
  - bit3 = para3 marker.
- `para1_out`  out  4  recovered para1 index; reset 4'h0.
- `para2_out`  out  6  recovered para2 index; reset 6'h00.
- `para3_out`  out  6  recovered para3 index; reset 6'h00.
- `found`  out  3  {p3,p2,p1} marker-seen flags for the last frame; reset 3'b000.
- `err`  out  4  error flags for the last frame; reset 4'h0.
  - bit0 = multi-hot.
  - bit1 = duplicate.
  - bit2 = para1 range.
  - bit3 = overflow.
- `frame_valid`  out  1  one-cycle pulse when the outputs above are updated; reset 0.
- `busy`  out  1  high while in RUN; reset 0.
- `stray_cnt`  out  8  saturating count of marker words seen outside a frame; reset 8'h00.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Working registers: 5-bit index `idx`, capture registers `cap1[3:0]`, `cap2[5:0]`, `cap3[5:0]`, working `fnd[2:0]`, working `er[3:0]`.
- IDLE:
  - `code_in[0]`=1: this word is index 0. Clear `fnd`/`er`/captures, process its marker bits at index 0, set `idx`=1, go to RUN.
  - `code_in[0]`=0 with any of bits 3:1 set: `stray_cnt` increments, saturating at 255.
- RUN, `code_in[0]`=1: process markers at the current `idx`, then increment `idx`.
  - A word arriving with `idx` already at 31 after a capture (i.e. the 33rd word) sets `er[3]`.
  - After that, markers are ignored and `idx` holds until the frame ends.
- RUN, `code_in[0]`=0: go to DONE. Marker bits in this word are ignored and are not counted as stray.
- Marker processing for one word:
  - More than one of bits 3:1 set: set `er[0]`, capture nothing from that word.
  - Exactly one bit set and its `fnd` bit already 1: set `er[1]`; the first capture is kept.
  - Otherwise capture `idx` into the matching register and set the `fnd` bit.
  - Para1 capture with `idx` > 15: set `er[2]`, store `idx[3:0]`, still set `fnd[0]`.
  - `cap2`/`cap3` are the zero-extended `idx`.
- DONE (one cycle):
  - Outputs `para*_out`, `found`, `err` take the working values; `frame_valid`=1.
  - If `code_in[0]`=1 in DONE, that word is index 0 of a new frame: same action as the IDLE start, go to RUN.
  - Otherwise go to IDLE.
- Outputs hold between frames and update only in DONE.
- A missing marker leaves its `found` bit 0 and its `para*_out` = 0.
- `rst` asserted mid-frame: immediately returns to IDLE and clears all outputs and working registers. No `frame_valid` is produced for the aborted frame.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Terminating word (bit0=0) sampled at edge E. After E: state DONE, `frame_valid`=1, outputs carry the new values. After E+1: `frame_valid`=0, outputs hold.
- `busy`=1 from the edge that samples the first frame word until the edge that samples the terminating word.
- Minimum frame gap is one word (the terminating word). Back-to-back frames with one zero word between them lose no data.
- Frame length 1..32 words is legal. 33 or more words sets overflow.

## Test plan
- Frame of 20 words (bit0=1), markers p1@3, p2@7, p3@12, then 0 → one `frame_valid`; para1=3, para2=7, para3=12, `found`=3'b111, `err`=0.
- Marker in word 0: code 4'b0011 as the first word, 9 more words, no other markers → para1=0, `found`=3'b001, para2=para3=0.
- Errors: p2 marker at idx 4 and again at idx 9; word 4'b1011 at idx 5; p1 at idx 20 → para2=4, `err`=4'b0111, `found`=3'b011.
- 40-word frame with p3 at idx 35 → `err[3]`=1, `found[2]`=0, `busy` high for 40 cycles.
- Two frames separated by exactly one 0 word; second frame's first word sampled in DONE → two `frame_valid` pulses 1 word + frame2 length apart, second frame's indices correct from 0.
- `rst` pulse at idx 10 of a frame → outputs zero immediately, no `frame_valid`. Marker words 4'b0100 ×3 in IDLE → `stray_cnt`=3.
